// File: rtl/adder_seq_pkg.sv
// Shared constants and state encoding for the nibble-serial adder sequencer.
package adder_seq_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Start/operand/result bundle between a wide-operand producer and the sequencer.
interface adder_seq_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/adder4b.sv
// Existing 4-bit ripple adder datapath, purely combinational.
module adder4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);
endmodule

// File: rtl/adder_seq_ctrl.sv
// Adds two WIDTH-bit operands one nibble per clock through a single shared adder4b.
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input logic             clk,
    input logic             rst,
    adder_seq_ctrl_if.slave bus
);
    localparam int unsigned NIB   = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [WIDTH-1:0]     a_q, b_q;
    logic                 carry_q;
    logic [WIDTH-1:0]     work_q, work_d;
    logic [WIDTH-1:0]     sum_q;
    logic                 cout_q;
    logic [NIBBLE_W-1:0]  nib_a, nib_b, nib_sum;
    logic                 nib_cout;

    // Select the current operand nibbles and merge the adder result into the working value
    always_comb begin
        nib_a  = a_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];
        nib_b  = b_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];
        work_d = work_q;
        work_d[int'(idx_q) * NIBBLE_W +: NIBBLE_W] = nib_sum;
    end

    adder4b u_adder4b (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN for NIB cycles, DONE for one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from registers, so nothing combinational reaches them from inputs
    always_comb begin
        bus.busy = (state_q == RUN);
        bus.done = (state_q == DONE);
        bus.sum  = sum_q;
        bus.cout = cout_q;
    end

    // Operand capture, nibble stepping and result update; sum/cout only move on the last nibble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    work_q  <= work_d;
                    carry_q <= nib_cout;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        sum_q  <= work_d;
                        cout_q <= nib_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
module tb_adder_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    adder_seq_ctrl_if #(.WIDTH(16)) bus16 ();
    adder_seq_ctrl_if #(.WIDTH(4))  bus4 ();

    adder_seq_ctrl #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    adder_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [16:0] q16[$];
    logic [4:0]  q4[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        logic [16:0] e16;
        if (rst === 1'b0 && bus16.done === 1'b1) begin
            if (q16.size() == 0) begin
                check_eq("done16_unexpected", 32'(bus16.done), 32'd0);
            end else begin
                e16 = q16.pop_front();
                check_eq("result16", 32'({bus16.cout, bus16.sum}), 32'(e16));
            end
        end
    end

    always @(negedge clk) begin
        logic [4:0] e4;
        if (rst === 1'b0 && bus4.done === 1'b1) begin
            if (q4.size() == 0) begin
                check_eq("done4_unexpected", 32'(bus4.done), 32'd0);
            end else begin
                e4 = q4.pop_front();
                check_eq("result4", 32'({bus4.cout, bus4.sum}), 32'(e4));
            end
        end
    end

    // One full addition on the 16-bit instance with timing and hold checks
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] prev;
        int lat;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        prev        = {bus16.cout, bus16.sum};
        bus16.start = 1'b1;
        bus16.a     = a;
        bus16.b     = b;
        bus16.cin   = cin;
        q16.push_back(17'(a) + 17'(b) + 17'(cin));
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        bus16.a     = ~a;
        bus16.b     = a ^ 16'h5A5A;
        bus16.cin   = ~cin;
        lat = 0;
        busy_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus16.done) begin
                seen = 1'b1;
                lat  = i;
                check_eq("busy_in_done16", 32'(bus16.busy), 32'd0);
            end else begin
                if (bus16.busy) busy_cnt++;
                check_eq("hold16", 32'({bus16.cout, bus16.sum}), 32'(prev));
            end
        end
        check_eq("done_seen16", 32'(seen), 32'd1);
        check_eq("latency16", 32'(lat), 32'd4);
        check_eq("busy_cycles16", 32'(busy_cnt), 32'd4);
        @(negedge clk);
        check_eq("done_pulse16", 32'(bus16.done), 32'd0);
    endtask

    initial begin
        int  done_cnt;
        bit  seen;
        logic [16:0] dropped;

        bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
        bus4.start  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.cin  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 32'(bus16.busy), 32'd0);
        check_eq("rst_done", 32'(bus16.done), 32'd0);
        check_eq("rst_sum", 32'(bus16.sum), 32'd0);
        check_eq("rst_cout", 32'(bus16.cout), 32'd0);
        rst = 1'b0;

        op16(16'h1234, 16'h1111, 1'b0);
        op16(16'hFFFF, 16'h0001, 1'b0);
        op16(16'hFFFF, 16'hFFFF, 1'b1);

        // start held high; operands churn during RUN, second operands presented in DONE
        @(negedge clk);
        bus16.start = 1'b1;
        bus16.a = 16'h0F0F; bus16.b = 16'h1010; bus16.cin = 1'b0;
        q16.push_back(17'h01F1F);
        @(posedge clk);
        for (int j = 0; j <= 6; j++) begin
            @(negedge clk);
            if (j < 4) begin
                check_eq("hold_busy", 32'(bus16.busy), 32'd1);
                bus16.a   = 16'($urandom);
                bus16.b   = 16'($urandom);
                bus16.cin = 1'($urandom);
            end else if (j == 4) begin
                check_eq("hold_done", 32'(bus16.done), 32'd1);
                bus16.a = 16'h8000; bus16.b = 16'h8000; bus16.cin = 1'b1;
                q16.push_back(17'h10001);
            end else if (j == 5) begin
                check_eq("gap_busy", 32'(bus16.busy), 32'd0);
                check_eq("gap_done", 32'(bus16.done), 32'd0);
            end else begin
                check_eq("reaccept_busy", 32'(bus16.busy), 32'd1);
                bus16.start = 1'b0;
            end
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus16.done) seen = 1'b1;
        end
        check_eq("second_done_seen", 32'(seen), 32'd1);

        // reset in the second RUN cycle discards the operation
        @(negedge clk);
        bus16.start = 1'b1;
        bus16.a = 16'h5555; bus16.b = 16'h2222; bus16.cin = 1'b0;
        q16.push_back(17'h07777);
        @(posedge clk);
        #1 bus16.start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_busy", 32'(bus16.busy), 32'd0);
        check_eq("arst_done", 32'(bus16.done), 32'd0);
        check_eq("arst_sum", 32'(bus16.sum), 32'd0);
        check_eq("arst_cout", 32'(bus16.cout), 32'd0);
        dropped = q16.pop_back();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus16.done) done_cnt++;
        end
        check_eq("no_done_after_rst", 32'(done_cnt), 32'd0);
        check_eq("idle_after_rst", 32'(bus16.busy), 32'd0);
        op16(16'h5555, 16'h2222, 1'b0);

        // WIDTH=4 instance: single RUN cycle
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.a = 4'hA; bus4.b = 4'h5; bus4.cin = 1'b1;
        q4.push_back(5'h10);
        @(posedge clk);
        #1 bus4.start = 1'b0;
        @(negedge clk);
        check_eq("w4_busy", 32'(bus4.busy), 32'd1);
        check_eq("w4_not_done", 32'(bus4.done), 32'd0);
        @(negedge clk);
        check_eq("w4_done", 32'(bus4.done), 32'd1);
        check_eq("w4_busy_off", 32'(bus4.busy), 32'd0);
        @(negedge clk);
        check_eq("w4_done_pulse", 32'(bus4.done), 32'd0);

        check_eq("q16_drained", 32'(q16.size()), 32'd0);
        check_eq("q4_drained", 32'(q4.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
